// File: rtl/ibp_update_sched.sv
// Indirect branch predictor update scheduler: shares one table port between lookups and queued updates.
// Optional steal counter statistics are compiled in with `define IBP_SCHED_STATS_EN.
//   state | meaning
//   IDLE  | arbitrate between lookups and FIFO updates
//   FLUSH | sweep every table entry to invalid, one per cycle
module ibp_update_sched #(
  parameter int ENTRIES      = 512,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lkp_req_i,
  output logic                       lkp_grant_o,
  input  logic                       upd_valid_i,
  output logic                       upd_ready_o,
  input  logic [63:0]                upd_pc_i,
  input  logic [63:0]                upd_target_i,
  output logic                       tbl_we_o,
  output logic                       tbl_wvalid_o,
  output logic [$clog2(ENTRIES)-1:0] tbl_widx_o,
  output logic [63:0]                tbl_wtag_o,
  output logic [63:0]                tbl_wtarget_o,
  input  logic                       flush_i,
  output logic                       flush_busy_o
`ifdef IBP_SCHED_STATS_EN
  ,
  output logic [31:0]                steal_cnt_o
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [63:0]        r_fifo_pc  [FIFO_DEPTH];
  logic [63:0]        r_fifo_tgt [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [AGE_W-1:0]   r_age;
  logic [IDX_W-1:0]   r_sweep_idx;

  logic               w_push;
  logic               w_pop;
  logic               w_nonempty;
  logic               w_full;
  logic               w_starved;
  logic [63:0]        w_head_pc;
  logic [63:0]        w_head_tgt;
  logic               w_flush_enter;

  assign w_nonempty    = (r_count != '0);
  assign w_full        = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_starved     = (r_age >= AGE_W'(STARVE_LIMIT - 1));
  assign w_head_pc     = r_fifo_pc[r_rd_ptr];
  assign w_head_tgt    = r_fifo_tgt[r_rd_ptr];
  assign upd_ready_o   = !w_full && (r_state == IDLE);
  assign w_push        = upd_valid_i && upd_ready_o;
  assign w_flush_enter = (r_state == IDLE) && flush_i;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    lkp_grant_o   = 1'b0;
    tbl_we_o      = 1'b0;
    tbl_wvalid_o  = 1'b0;
    tbl_widx_o    = '0;
    tbl_wtag_o    = '0;
    tbl_wtarget_o = '0;
    flush_busy_o  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_nonempty && (!lkp_req_i || w_starved || w_full)) begin
          w_pop         = 1'b1;
          tbl_we_o      = 1'b1;
          tbl_wvalid_o  = 1'b1;
          tbl_widx_o    = w_head_pc[IDX_W-1:0] ^ w_head_tgt[IDX_W-1:0];
          tbl_wtag_o    = w_head_pc;
          tbl_wtarget_o = w_head_tgt;
        end else begin
          lkp_grant_o = lkp_req_i;
        end
        if (flush_i) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        tbl_we_o     = 1'b1;
        tbl_widx_o   = r_sweep_idx;
        flush_busy_o = 1'b1;
        if (r_sweep_idx == IDX_W'(ENTRIES - 1)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Flush entry overrides this cycle's push/pop bookkeeping: the queue is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_age       <= '0;
      r_sweep_idx <= '0;
    end else if (w_flush_enter) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_age       <= '0;
      r_sweep_idx <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop || !w_nonempty)
        r_age <= '0;
      else if (!w_starved)
        r_age <= r_age + AGE_W'(1);
      if (r_state == FLUSH)
        r_sweep_idx <= (r_sweep_idx == IDX_W'(ENTRIES - 1)) ? '0 : r_sweep_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]  <= upd_pc_i;
      r_fifo_tgt[r_wr_ptr] <= upd_target_i;
    end
  end

`ifdef IBP_SCHED_STATS_EN
  logic [31:0] r_steal_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_steal_cnt <= '0;
    else if (w_pop && lkp_req_i && (r_steal_cnt != 32'hFFFF_FFFF))
      r_steal_cnt <= r_steal_cnt + 32'd1;
  end

  assign steal_cnt_o = r_steal_cnt;
`endif

endmodule

// File: tb/tb_ibp_update_sched.sv
// Directed bench for ibp_update_sched: update arbitration, starvation, full FIFO, flush sweep, reset abort.
// Define IBP_SCHED_STATS_EN to also exercise the steal counter.
module tb_ibp_update_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        lkp_req_i;
  logic        lkp_grant_o;
  logic        upd_valid_i;
  logic        upd_ready_o;
  logic [63:0] upd_pc_i;
  logic [63:0] upd_target_i;
  logic        tbl_we_o;
  logic        tbl_wvalid_o;
  logic [8:0]  tbl_widx_o;
  logic [63:0] tbl_wtag_o;
  logic [63:0] tbl_wtarget_o;
  logic        flush_i;
  logic        flush_busy_o;
`ifdef IBP_SCHED_STATS_EN
  logic [31:0] steal_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  ibp_update_sched #(.ENTRIES(512), .FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .lkp_req_i    (lkp_req_i),
    .lkp_grant_o  (lkp_grant_o),
    .upd_valid_i  (upd_valid_i),
    .upd_ready_o  (upd_ready_o),
    .upd_pc_i     (upd_pc_i),
    .upd_target_i (upd_target_i),
    .tbl_we_o     (tbl_we_o),
    .tbl_wvalid_o (tbl_wvalid_o),
    .tbl_widx_o   (tbl_widx_o),
    .tbl_wtag_o   (tbl_wtag_o),
    .tbl_wtarget_o(tbl_wtarget_o),
    .flush_i      (flush_i),
    .flush_busy_o (flush_busy_o)
`ifdef IBP_SCHED_STATS_EN
    ,
    .steal_cnt_o  (steal_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int sweep_ok;
  logic [63:0] pcs [4];

  initial begin
    rst = 1'b1; lkp_req_i = 1'b0; upd_valid_i = 1'b0; flush_i = 1'b0;
    upd_pc_i = '0; upd_target_i = '0;
    tick(); tick();
    #1;
    chk("rst_ready", 64'(upd_ready_o), 64'd1);
    chk("rst_grant", 64'(lkp_grant_o), 64'd0);
    chk("rst_we",    64'(tbl_we_o), 64'd0);
    chk("rst_busy",  64'(flush_busy_o), 64'd0);
    chk("rst_widx",  64'(tbl_widx_o), 64'd0);
    chk("rst_tag",   tbl_wtag_o, 64'd0);
`ifdef IBP_SCHED_STATS_EN
    chk("rst_steal", 64'(steal_cnt_o), 64'd0);
`endif
    rst = 1'b0;

    // idle lookup port: update written the cycle after the push
    upd_valid_i = 1'b1; upd_pc_i = 64'h1000; upd_target_i = 64'h1234;
    tick();
    upd_valid_i = 1'b0;
    #1;
    chk("wr1_we",     64'(tbl_we_o), 64'd1);
    chk("wr1_widx",   64'(tbl_widx_o), 64'h034);
    chk("wr1_tag",    tbl_wtag_o, 64'h1000);
    chk("wr1_tgt",    tbl_wtarget_o, 64'h1234);
    chk("wr1_wvalid", 64'(tbl_wvalid_o), 64'd1);
    chk("wr1_grant",  64'(lkp_grant_o), 64'd0);
    tick(); #1;
    chk("wr1_drain_we",   64'(tbl_we_o), 64'd0);
    chk("wr1_drain_widx", 64'(tbl_widx_o), 64'd0);

    upd_valid_i = 1'b1; upd_pc_i = 64'hFFFF_0000_0000_01FF; upd_target_i = 64'h100;
    tick();
    upd_valid_i = 1'b0;
    #1;
    chk("wr2_widx", 64'(tbl_widx_o), 64'h0FF);
    chk("wr2_tag",  tbl_wtag_o, 64'hFFFF_0000_0000_01FF);
    tick(); #1;

    // starvation: lookups keep the port for 7 cycles, then the update is forced
    lkp_req_i = 1'b1;
    upd_valid_i = 1'b1; upd_pc_i = 64'h2000; upd_target_i = 64'h2005;
    tick();
    upd_valid_i = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      #1;
      chk($sformatf("starve_grant_c%0d", i), 64'(lkp_grant_o), 64'd1);
      chk($sformatf("starve_we_c%0d", i), 64'(tbl_we_o), 64'd0);
      tick();
    end
    #1;
    chk("starve_we_c8",    64'(tbl_we_o), 64'd1);
    chk("starve_grant_c8", 64'(lkp_grant_o), 64'd0);
    chk("starve_widx_c8",  64'(tbl_widx_o), 64'h005);
    tick(); #1;
    chk("starve_after_grant", 64'(lkp_grant_o), 64'd1);
    chk("starve_after_we",    64'(tbl_we_o), 64'd0);
`ifdef IBP_SCHED_STATS_EN
    chk("steal_cnt", 64'(steal_cnt_o), 64'd1);
`endif

    // full FIFO forces a pop even with lookups pending
    pcs[0] = 64'h3000; pcs[1] = 64'h3100; pcs[2] = 64'h3200; pcs[3] = 64'h3300;
    for (int k = 0; k < 4; k++) begin
      upd_valid_i = 1'b1; upd_pc_i = pcs[k]; upd_target_i = 64'h0;
      tick();
    end
    upd_valid_i = 1'b0;
    #1;
    chk("full_ready", 64'(upd_ready_o), 64'd0);
    chk("full_we",    64'(tbl_we_o), 64'd1);
    chk("full_grant", 64'(lkp_grant_o), 64'd0);
    chk("full_tag",   tbl_wtag_o, 64'h3000);
    tick(); #1;
    chk("full_after_ready", 64'(upd_ready_o), 64'd1);
    chk("full_after_grant", 64'(lkp_grant_o), 64'd1);
    lkp_req_i = 1'b0;
    for (int k = 1; k < 4; k++) begin
      #1;
      chk($sformatf("drain_tag%0d", k), tbl_wtag_o, pcs[k]);
      chk($sformatf("drain_idx%0d", k), 64'(tbl_widx_o), pcs[k] & 64'h1FF);
      tick();
    end
    #1;
    chk("drain_empty_we", 64'(tbl_we_o), 64'd0);

    // flush with two queued updates: queue dropped, full invalidating sweep
    lkp_req_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      upd_valid_i = 1'b1; upd_pc_i = 64'h4000 + 64'(k); upd_target_i = 64'h0;
      tick();
    end
    upd_valid_i = 1'b0;
    flush_i = 1'b1;
    #1;
    chk("flush_cycle_grant", 64'(lkp_grant_o), 64'd1);
    tick();
    flush_i = 1'b0;
    sweep_ok = 0;
    for (int i = 0; i < 512; i++) begin
      flush_i = (i == 10);
      #1;
      if (tbl_we_o === 1'b1 && tbl_wvalid_o === 1'b0 && tbl_widx_o === 9'(i) &&
          tbl_wtag_o === 64'd0 && tbl_wtarget_o === 64'd0 && flush_busy_o === 1'b1 &&
          lkp_grant_o === 1'b0 && upd_ready_o === 1'b0)
        sweep_ok++;
      tick();
    end
    flush_i = 1'b0;
    chk("sweep_good_cycles", 64'(sweep_ok), 64'd512);
    #1;
    chk("post_flush_busy",  64'(flush_busy_o), 64'd0);
    chk("post_flush_ready", 64'(upd_ready_o), 64'd1);
    chk("post_flush_grant", 64'(lkp_grant_o), 64'd1);
    lkp_req_i = 1'b0;
    #1;
    chk("post_flush_dropped", 64'(tbl_we_o), 64'd0);

    // reset in the middle of a sweep abandons it
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    #1;
    chk("midflush_idx",  64'(tbl_widx_o), 64'd100);
    chk("midflush_busy", 64'(flush_busy_o), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_flush_busy",  64'(flush_busy_o), 64'd0);
    chk("rst_flush_ready", 64'(upd_ready_o), 64'd1);
    chk("rst_flush_we",    64'(tbl_we_o), 64'd0);
    tick(); tick(); #1;
    chk("rst_flush_no_resweep", 64'(tbl_we_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
